// File: rtl/lift_window_gen.sv
// Row buffer and neighbourhood issuer feeding the 5/3 lift_step stage.
// Loads one row, then emits {left, sam, right} triples for odd or even indices.
module lift_window_gen #(
  parameter int ROW_LEN = 16,
  parameter int DW      = 9,
  parameter int IW      = $clog2(ROW_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          pass_i,
  input  logic          fwd_i,
  input  logic [DW-1:0] din_i,
  input  logic          din_vld_i,
  output logic          din_rdy_o,
  input  logic          hold_i,
  output logic [DW-1:0] left_o,
  output logic [DW-1:0] sam_o,
  output logic [DW-1:0] right_o,
  output logic [3:0]    flgs_o,
  output logic          update_o,
  output logic [IW-1:0] idx_o,
  output logic          busy_o,
  output logic          done_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // LOAD   | accepting ROW_LEN samples into the row buffer
  // ISSUE  | emitting one triple per non-held cycle
  // FIN    | last triple on the outputs; done_o follows
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_FIN} state_t;

  localparam logic [IW-1:0] LAST_IDX  = IW'(ROW_LEN - 1);
  localparam logic [IW-1:0] LAST_PAIR = IW'(ROW_LEN - 2);

  state_t          state_q, state_d;
  logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]   k_q, k_d;
  logic            pass_q, pass_d;
  logic            fwd_q, fwd_d;
  logic [DW-1:0]   row_q [ROW_LEN];
  logic [DW-1:0]   row_d [ROW_LEN];
  logic [DW-1:0]   left_q, left_d;
  logic [DW-1:0]   sam_q, sam_d;
  logic [DW-1:0]   right_q, right_d;
  logic [3:0]      flgs_q, flgs_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            update_q, update_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            din_rdy_q, din_rdy_d;
  logic [IW-1:0]   k_lft, k_rgt;

  // Symmetric extension: mirror x[1] at the left edge, x[N-2] at the right edge.
  always_comb begin
    k_lft = (k_q == '0) ? IW'(1) : k_q - IW'(1);
    k_rgt = (k_q == LAST_IDX) ? LAST_PAIR : k_q + IW'(1);
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    k_d      = k_q;
    pass_d   = pass_q;
    fwd_d    = fwd_q;
    row_d    = row_q;
    left_d   = left_q;
    sam_d    = sam_q;
    right_d  = right_q;
    flgs_d   = flgs_q;
    idx_d    = idx_q;
    update_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pass_d   = pass_i;
          fwd_d    = fwd_i;
          wr_ptr_d = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (din_vld_i) begin
          row_d[wr_ptr_q] = din_i;
          wr_ptr_d        = wr_ptr_q + IW'(1);
          if (wr_ptr_q == LAST_IDX) begin
            state_d = S_ISSUE;
            k_d     = pass_q ? IW'(0) : IW'(1);
          end
        end
      end
      S_ISSUE: begin
        if (!hold_i) begin
          left_d   = row_q[k_lft];
          sam_d    = row_q[k_q];
          right_d  = row_q[k_rgt];
          flgs_d   = {1'b0, 1'b1, pass_q, fwd_q};
          idx_d    = k_q;
          update_d = 1'b1;
          k_d      = k_q + IW'(2);
          if (k_q >= LAST_PAIR) state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d != S_IDLE);
    din_rdy_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      k_q       <= '0;
      pass_q    <= 1'b0;
      fwd_q     <= 1'b0;
      left_q    <= '0;
      sam_q     <= '0;
      right_q   <= '0;
      flgs_q    <= '0;
      idx_q     <= '0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      din_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      k_q       <= k_d;
      pass_q    <= pass_d;
      fwd_q     <= fwd_d;
      left_q    <= left_d;
      sam_q     <= sam_d;
      right_q   <= right_d;
      flgs_q    <= flgs_d;
      idx_q     <= idx_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      din_rdy_q <= din_rdy_d;
    end
  end

  // Row storage is deliberately left out of reset; it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

  assign din_rdy_o = din_rdy_q;
  assign left_o    = left_q;
  assign sam_o     = sam_q;
  assign right_o   = right_q;
  assign flgs_o    = flgs_q;
  assign update_o  = update_q;
  assign idx_o     = idx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_lift_window_gen.sv
// Directed bench for lift_window_gen with an 8-sample row and hand-computed triples.
module tb_lift_window_gen;
  localparam int ROW_LEN = 8;
  localparam int DW      = 9;
  localparam int IW      = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0, pass_i = 1'b0, fwd_i = 1'b0;
  logic [DW-1:0] din_i = '0;
  logic          din_vld_i = 1'b0, hold_i = 1'b0;
  logic          din_rdy_o, update_o, busy_o, done_o;
  logic [DW-1:0] left_o, sam_o, right_o;
  logic [3:0]    flgs_o;
  logic [IW-1:0] idx_o;

  int total = 0;
  int fails = 0;
  int exp_idx [4];
  int exp_l [4];
  int exp_s [4];
  int exp_r [4];
  int exp_flg;

  lift_window_gen #(.ROW_LEN(ROW_LEN), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pass_i(pass_i), .fwd_i(fwd_i),
    .din_i(din_i), .din_vld_i(din_vld_i), .din_rdy_o(din_rdy_o), .hold_i(hold_i),
    .left_o(left_o), .sam_o(sam_o), .right_o(right_o), .flgs_o(flgs_o),
    .update_o(update_o), .idx_o(idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"}, 32'(din_rdy_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_upd"}, 32'(update_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_idx"}, 32'(idx_o), 0);
    chk({tag, "_data"}, {left_o, sam_o, right_o} == '0 ? 32'd0 : 32'd1, 0);
    chk({tag, "_flgs"}, 32'(flgs_o), 0);
  endtask

  task automatic set_pred();
    exp_idx = '{1, 3, 5, 7};
    exp_l   = '{10, 30, 50, 70};
    exp_s   = '{20, 40, 60, 80};
    exp_r   = '{30, 50, 70, 70};
    exp_flg = 5;
  endtask

  task automatic set_upd();
    exp_idx = '{0, 2, 4, 6};
    exp_l   = '{20, 20, 40, 60};
    exp_s   = '{10, 30, 50, 70};
    exp_r   = '{20, 40, 60, 80};
    exp_flg = 6;
  endtask

  task automatic start_row(input logic p, input logic f);
    start_i = 1'b1; pass_i = p; fwd_i = f;
    tick();
    start_i = 1'b0;
    chk("start_rdy", 32'(din_rdy_o), 1);
    chk("start_busy", 32'(busy_o), 1);
  endtask

  // Gap cycles present junk data with valid low and pulse start_i.
  task automatic load_row(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        din_vld_i = 1'b0; din_i = 9'd99; start_i = 1'b1;
        tick();
        start_i = 1'b0;
      end
      din_vld_i = 1'b1;
      din_i = DW'(10 * (i + 1));
      tick();
    end
    din_vld_i = 1'b0;
    din_i = '0;
  endtask

  task automatic run_issue(input int hold_len, input bit start_pulse, input bit b2b,
                           input logic b_pass, input logic b_fwd);
    int n = 0;
    int hold_left = 0;
    bit held = 0;
    bit got_done = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      start_i = start_pulse && (t == 1);
      if (hold_left > 0) begin
        chk("hold_upd", 32'(update_o), 0);
        chk("hold_idx", 32'(idx_o), 32'(exp_idx[1]));
        chk("hold_sam", 32'(sam_o), 32'(exp_s[1]));
        hold_left--;
        if (hold_left == 0) hold_i = 1'b0;
      end else if (update_o) begin
        if (n < 4) begin
          chk("idx", 32'(idx_o), 32'(exp_idx[n]));
          chk("left", 32'(left_o), 32'(exp_l[n]));
          chk("sam", 32'(sam_o), 32'(exp_s[n]));
          chk("right", 32'(right_o), 32'(exp_r[n]));
          chk("flgs", 32'(flgs_o), 32'(exp_flg));
          chk("issue_rdy", 32'(din_rdy_o), 0);
        end
        n++;
        if (n == 2 && hold_len > 0 && !held) begin
          hold_i = 1'b1; hold_left = hold_len; held = 1;
        end
      end
      if (done_o) begin
        got_done = 1;
        chk("done_cycle", 32'(t), 32'(ROW_LEN / 2 + 1 + hold_len));
        chk("strobes", 32'(n), 4);
        chk("done_busy", 32'(busy_o), 0);
        chk("done_upd", 32'(update_o), 0);
        if (b2b) begin
          start_i = 1'b1; pass_i = b_pass; fwd_i = b_fwd;
          tick();
          start_i = 1'b0;
          chk("b2b_rdy", 32'(din_rdy_o), 1);
          chk("b2b_busy", 32'(busy_o), 1);
        end
        break;
      end
    end
    start_i = 1'b0;
    hold_i = 1'b0;
    chk("done_seen", 32'(got_done), 1);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk_zero("reset");

    // Predict forward, then back-to-back update inverse.
    set_pred();
    start_row(1'b0, 1'b1);
    load_row(ROW_LEN, 0);
    run_issue(0, 0, 1, 1'b1, 1'b0);
    set_upd();
    load_row(ROW_LEN, 0);
    run_issue(0, 0, 0, 1'b0, 1'b0);

    // Downstream stall after the second strobe.
    set_pred();
    start_row(1'b0, 1'b1);
    load_row(ROW_LEN, 0);
    run_issue(3, 0, 0, 1'b0, 1'b0);

    // Valid gaps and stray start pulses during LOAD and ISSUE.
    start_row(1'b0, 1'b1);
    load_row(ROW_LEN, 1);
    run_issue(0, 1, 0, 1'b0, 1'b0);

    // Reset partway through a load, then a clean row.
    start_row(1'b0, 1'b1);
    load_row(5, 0);
    rst = 1'b1;
    tick();
    chk_zero("midrst");
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy_o), 0);
    start_row(1'b0, 1'b1);
    load_row(ROW_LEN, 0);
    run_issue(0, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
